// File: rtl/matadd4_seq.sv
// matadd4_seq
//   Time-multiplexed 4-operand matrix adder. The operand matrices a, b, c and d
//   are captured when a start request is accepted. One shared add4 adder then
//   walks every element in row-major order, one element per clock. The finished
//   result matrix f is handed to the consumer through a valid/ready handshake.
//   This trades throughput for area against a fully parallel ROWS*COLS adder
//   array.
//
// Parameters
//   ROWS, COLS  matrix shape (both >= 1); a shape of 1xN or Nx1 is a vector
//   WIDTH       add4 fixed-point element width; sums wrap modulo 2**WIDTH
//
// Ports
//   clk        rising-edge clock
//   reset_l    asynchronous active-low reset
//   start      request to capture a..d and begin; accepted when start & start_rdy
//   start_rdy  high only while idle
//   clear      synchronous abort back to idle; wins over start and f_rdy
//   a,b,c,d    operand matrices [ROWS:1][COLS:1], sampled only at accept
//   f          result matrix register
//   f_valid    f holds a complete result
//   f_rdy      consumer takes f when f_valid & f_rdy
//   busy       high while stepping or holding a finished result
module matadd4_seq #(
    parameter int ROWS  = 1,
    parameter int COLS  = 1,
    parameter int WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                reset_l,
    input  logic                                start,
    output logic                                start_rdy,
    input  logic                                clear,
    input  logic [ROWS:1][COLS:1][WIDTH-1:0]    a,
    input  logic [ROWS:1][COLS:1][WIDTH-1:0]    b,
    input  logic [ROWS:1][COLS:1][WIDTH-1:0]    c,
    input  logic [ROWS:1][COLS:1][WIDTH-1:0]    d,
    output logic [ROWS:1][COLS:1][WIDTH-1:0]    f,
    output logic                                f_valid,
    input  logic                                f_rdy,
    output logic                                busy
);

    // The counters are 1-based, so they need enough bits to hold ROWS and COLS.
    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                              state;
    state_t                              state_nxt;
    logic [ROWS:1][COLS:1][WIDTH-1:0]    opa;
    logic [ROWS:1][COLS:1][WIDTH-1:0]    opb;
    logic [ROWS:1][COLS:1][WIDTH-1:0]    opc;
    logic [ROWS:1][COLS:1][WIDTH-1:0]    opd;
    logic [RW-1:0]                       row;
    logic [CW-1:0]                       col;
    logic                                accept;
    logic                                step;
    logic                                last;
    logic [WIDTH-1:0]                    sum;

    // The add4 element adder. Its result is truncated to WIDTH, so it is
    // bit-identical to each cell of the parallel matrix adder.
    function automatic logic [WIDTH-1:0] add4(
        input logic [WIDTH-1:0] x0,
        input logic [WIDTH-1:0] x1,
        input logic [WIDTH-1:0] x2,
        input logic [WIDTH-1:0] x3
    );
        return x0 + x1 + x2 + x3;
    endfunction

    // The single shared adder, steered by the element counters.
    assign sum  = add4(opa[row][col], opb[row][col], opc[row][col], opd[row][col]);
    assign last = (row == LAST_ROW) && (col == LAST_COL);

    assign start_rdy = (state == IDLE);
    assign f_valid   = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. clear overrides everything, so an abort in the same
    // cycle as start or f_rdy neither captures operands nor hands off f.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    step = 1'b1;
                    if (last) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (f_rdy) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath. Operands are frozen at accept. f is written only while
    // stepping, one element per cycle. After the last element, row runs one
    // past ROWS; that value is never used, because the next accept reloads it.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            opa <= '0;
            opb <= '0;
            opc <= '0;
            opd <= '0;
            row <= '0;
            col <= '0;
            f   <= '0;
        end else if (accept) begin
            opa <= a;
            opb <= b;
            opc <= c;
            opd <= d;
            row <= RW'(1);
            col <= CW'(1);
        end else if (step) begin
            f[row][col] <= sum;
            if (col == LAST_COL) begin
                col <= CW'(1);
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_matadd4_seq.sv
// tb_matadd4_seq
//   Directed bench for matadd4_seq. It uses four instances (2x2, 1x1, 3x2 and
//   2x3) with an 8-bit width. Each expected matrix is a plain element-wise
//   a+b+c+d, truncated to 8 bits and computed from operand copies held by the
//   bench.
module tb_matadd4_seq;

    typedef logic [2:1][2:1][7:0] m22_t;
    typedef logic [1:1][1:1][7:0] m11_t;
    typedef logic [3:1][2:1][7:0] m32_t;
    typedef logic [2:1][3:1][7:0] m23_t;

    logic clk     = 1'b0;
    logic reset_l = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    logic start_22, start_rdy_22, clear_22, f_valid_22, f_rdy_22, busy_22;
    m22_t a_22, b_22, c_22, d_22, f_22;
    logic start_11, start_rdy_11, clear_11, f_valid_11, f_rdy_11, busy_11;
    m11_t a_11, b_11, c_11, d_11, f_11;
    logic start_32, start_rdy_32, clear_32, f_valid_32, f_rdy_32, busy_32;
    m32_t a_32, b_32, c_32, d_32, f_32;
    logic start_23, start_rdy_23, clear_23, f_valid_23, f_rdy_23, busy_23;
    m23_t a_23, b_23, c_23, d_23, f_23;

    matadd4_seq #(.ROWS(2), .COLS(2), .WIDTH(8)) dut22 (
        .clk(clk), .reset_l(reset_l), .start(start_22), .start_rdy(start_rdy_22),
        .clear(clear_22), .a(a_22), .b(b_22), .c(c_22), .d(d_22), .f(f_22),
        .f_valid(f_valid_22), .f_rdy(f_rdy_22), .busy(busy_22)
    );
    matadd4_seq #(.ROWS(1), .COLS(1), .WIDTH(8)) dut11 (
        .clk(clk), .reset_l(reset_l), .start(start_11), .start_rdy(start_rdy_11),
        .clear(clear_11), .a(a_11), .b(b_11), .c(c_11), .d(d_11), .f(f_11),
        .f_valid(f_valid_11), .f_rdy(f_rdy_11), .busy(busy_11)
    );
    matadd4_seq #(.ROWS(3), .COLS(2), .WIDTH(8)) dut32 (
        .clk(clk), .reset_l(reset_l), .start(start_32), .start_rdy(start_rdy_32),
        .clear(clear_32), .a(a_32), .b(b_32), .c(c_32), .d(d_32), .f(f_32),
        .f_valid(f_valid_32), .f_rdy(f_rdy_32), .busy(busy_32)
    );
    matadd4_seq #(.ROWS(2), .COLS(3), .WIDTH(8)) dut23 (
        .clk(clk), .reset_l(reset_l), .start(start_23), .start_rdy(start_rdy_23),
        .clear(clear_23), .a(a_23), .b(b_23), .c(c_23), .d(d_23), .f(f_23),
        .f_valid(f_valid_23), .f_rdy(f_rdy_23), .busy(busy_23)
    );

    always #5 clk = ~clk;

    // Reset state on every instance, then start_rdy once reset is released.
    task automatic test_reset();
        reset_l = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({f_valid_22, f_valid_11, f_valid_32, f_valid_23} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_f_valid got=%b want=0000", {f_valid_22, f_valid_11, f_valid_32, f_valid_23});
        end
        total++;
        if ({busy_22, busy_11, busy_32, busy_23} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_busy got=%b want=0000", {busy_22, busy_11, busy_32, busy_23});
        end
        total++;
        if (f_22 !== '0 || f_11 !== '0 || f_32 !== '0 || f_23 !== '0) begin
            bad++;
            $display("[TB] FAIL reset_f got=%h/%h/%h/%h want=0", f_22, f_11, f_32, f_23);
        end
        reset_l = 1'b1;
        @(negedge clk);
        total++;
        if ({start_rdy_22, start_rdy_11, start_rdy_32, start_rdy_23} !== 4'b1111) begin
            bad++;
            $display("[TB] FAIL reset_start_rdy got=%b want=1111", {start_rdy_22, start_rdy_11, start_rdy_32, start_rdy_23});
        end
    endtask

    // 2x2 with every element 1+2+3+4: the result is valid after 5 edges.
    task automatic test_basic_2x2();
        int edges;
        bit seen;
        a_22 = {4{8'd1}};
        b_22 = {4{8'd2}};
        c_22 = {4{8'd3}};
        d_22 = {4{8'd4}};
        @(negedge clk);
        start_22 = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            start_22 = 1'b0;
            if (edges == 1) begin
                total++;
                if (busy_22 !== 1'b1 || start_rdy_22 !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL basic_run_flags got busy=%b start_rdy=%b want 1/0", busy_22, start_rdy_22);
                end
            end
            seen = (f_valid_22 === 1'b1);
        end
        total++;
        if (!seen || edges != 5) begin
            bad++;
            $display("[TB] FAIL basic_latency got=%0d edges (seen=%0b) want=5", edges, seen);
        end
        for (int ri = 1; ri <= 2; ri++) begin
            for (int ci = 1; ci <= 2; ci++) begin
                total++;
                if (f_22[ri][ci] !== 8'd10) begin
                    bad++;
                    $display("[TB] FAIL basic_f[%0d][%0d] got=%0d want=10", ri, ci, f_22[ri][ci]);
                end
            end
        end
        @(negedge clk);
        f_rdy_22 = 1'b1;
        @(posedge clk);
        #1;
        f_rdy_22 = 1'b0;
        total++;
        if (f_valid_22 !== 1'b0 || start_rdy_22 !== 1'b1 || busy_22 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_handoff got f_valid=%b start_rdy=%b busy=%b want 0/1/0", f_valid_22, start_rdy_22, busy_22);
        end
    endtask

    // 1x1 (5+6+7+8=26) with f_rdy held high throughout. f_rdy must be ignored
    // in RUN, so DONE still lasts one cycle.
    task automatic test_1x1();
        int edges;
        bit seen;
        a_11 = 8'd5;
        b_11 = 8'd6;
        c_11 = 8'd7;
        d_11 = 8'd8;
        f_rdy_11 = 1'b1;
        @(negedge clk);
        start_11 = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            start_11 = 1'b0;
            seen = (f_valid_11 === 1'b1);
        end
        total++;
        if (!seen || edges != 2) begin
            bad++;
            $display("[TB] FAIL 1x1_latency got=%0d edges (seen=%0b) want=2", edges, seen);
        end
        total++;
        if (f_11[1][1] !== 8'd26) begin
            bad++;
            $display("[TB] FAIL 1x1_f got=%0d want=26", f_11[1][1]);
        end
        @(posedge clk);
        #1;
        f_rdy_11 = 1'b0;
        total++;
        if (f_valid_11 !== 1'b0 || start_rdy_11 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL 1x1_handoff got f_valid=%b start_rdy=%b want 0/1", f_valid_11, start_rdy_11);
        end
    endtask

    // 3x2 with distinct elements. a is overwritten right after accept. Each
    // step must write the next row-major element and leave the one after it
    // still untouched.
    task automatic test_3x2_capture();
        m32_t exp;
        int ri;
        int ci;
        for (int r = 1; r <= 3; r++) begin
            for (int k = 1; k <= 2; k++) begin
                a_32[r][k] = 8'(r * 10 + k);
            end
        end
        b_32 = '0;
        c_32 = '0;
        d_32 = '0;
        for (int r = 1; r <= 3; r++) begin
            for (int k = 1; k <= 2; k++) begin
                exp[r][k] = a_32[r][k] + b_32[r][k] + c_32[r][k] + d_32[r][k];
            end
        end
        @(negedge clk);
        start_32 = 1'b1;
        @(posedge clk);
        #1;
        start_32 = 1'b0;
        a_32 = '1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            ri = (k - 1) / 2 + 1;
            ci = (k - 1) % 2 + 1;
            total++;
            if (f_32[ri][ci] !== exp[ri][ci]) begin
                bad++;
                $display("[TB] FAIL 3x2_step%0d f[%0d][%0d] got=%0d want=%0d", k, ri, ci, f_32[ri][ci], exp[ri][ci]);
            end
            if (k < 6) begin
                ri = k / 2 + 1;
                ci = k % 2 + 1;
                total++;
                if (f_32[ri][ci] !== 8'd0) begin
                    bad++;
                    $display("[TB] FAIL 3x2_order%0d f[%0d][%0d] got=%0d want=0", k, ri, ci, f_32[ri][ci]);
                end
            end
        end
        total++;
        if (f_valid_32 !== 1'b1 || f_32 !== exp) begin
            bad++;
            $display("[TB] FAIL 3x2_done got f_valid=%b f=%h want 1 f=%h", f_valid_32, f_32, exp);
        end
        @(negedge clk);
        f_rdy_32 = 1'b1;
        @(posedge clk);
        #1;
        f_rdy_32 = 1'b0;
        total++;
        if (f_valid_32 !== 1'b0 || start_rdy_32 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL 3x2_handoff got f_valid=%b start_rdy=%b want 0/1", f_valid_32, start_rdy_32);
        end
    endtask

    // 2x2 with a sum that overflows 8 bits. The result is held in DONE for 10
    // cycles while a start pulse with new operands is ignored.
    task automatic test_hold_done();
        m22_t exp;
        int edges;
        bit seen;
        for (int r = 1; r <= 2; r++) begin
            for (int k = 1; k <= 2; k++) begin
                a_22[r][k] = 8'(r + k);
            end
        end
        b_22 = {4{8'd100}};
        c_22 = {4{8'd200}};
        d_22 = {4{8'd7}};
        for (int r = 1; r <= 2; r++) begin
            for (int k = 1; k <= 2; k++) begin
                exp[r][k] = a_22[r][k] + b_22[r][k] + c_22[r][k] + d_22[r][k];
            end
        end
        @(negedge clk);
        start_22 = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            start_22 = 1'b0;
            seen = (f_valid_22 === 1'b1);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL hold_reach_done got=timeout after %0d edges want=f_valid", edges);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (f_valid_22 !== 1'b1 || f_22 !== exp || start_rdy_22 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL hold_cycle%0d got f_valid=%b f=%h start_rdy=%b want 1 f=%h 0", i, f_valid_22, f_22, start_rdy_22, exp);
            end
            if (i == 4) begin
                start_22 = 1'b1;
                a_22 = {4{8'hff}};
            end else begin
                start_22 = 1'b0;
            end
        end
        f_rdy_22 = 1'b1;
        @(posedge clk);
        #1;
        f_rdy_22 = 1'b0;
        total++;
        if (f_valid_22 !== 1'b0 || start_rdy_22 !== 1'b1 || f_22 !== exp) begin
            bad++;
            $display("[TB] FAIL hold_handoff got f_valid=%b start_rdy=%b f=%h want 0/1 f=%h", f_valid_22, start_rdy_22, f_22, exp);
        end
    endtask

    // 2x3 aborted by clear while element 3 is in flight. A clear+start pair in
    // IDLE must not start. Then a fresh run with overflowing operands is made.
    task automatic test_clear();
        m23_t exp;
        int edges;
        bit seen;
        bit leaked;
        for (int r = 1; r <= 2; r++) begin
            for (int k = 1; k <= 3; k++) begin
                a_23[r][k] = 8'(r * 10 + k);
            end
        end
        b_23 = {6{8'd1}};
        c_23 = {6{8'd1}};
        d_23 = {6{8'd1}};
        @(negedge clk);
        start_23 = 1'b1;
        @(posedge clk);
        #1;
        start_23 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        clear_23 = 1'b1;
        @(posedge clk);
        #1;
        clear_23 = 1'b0;
        total++;
        if (start_rdy_23 !== 1'b1 || busy_23 !== 1'b0 || f_valid_23 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clear_idle got start_rdy=%b busy=%b f_valid=%b want 1/0/0", start_rdy_23, busy_23, f_valid_23);
        end
        total++;
        if (f_23[1][1] !== 8'd14) begin
            bad++;
            $display("[TB] FAIL clear_partial got=%0d want=14", f_23[1][1]);
        end
        leaked = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (f_valid_23 !== 1'b0) leaked = 1'b1;
        end
        total++;
        if (leaked) begin
            bad++;
            $display("[TB] FAIL clear_no_valid got=f_valid pulse want=none");
        end
        start_23 = 1'b1;
        clear_23 = 1'b1;
        @(posedge clk);
        #1;
        start_23 = 1'b0;
        clear_23 = 1'b0;
        total++;
        if (start_rdy_23 !== 1'b1 || busy_23 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clear_beats_start got start_rdy=%b busy=%b want 1/0", start_rdy_23, busy_23);
        end
        for (int r = 1; r <= 2; r++) begin
            for (int k = 1; k <= 3; k++) begin
                a_23[r][k] = 8'h80;
                b_23[r][k] = 8'h80;
                c_23[r][k] = 8'(r);
                d_23[r][k] = 8'(k);
                exp[r][k]  = a_23[r][k] + b_23[r][k] + c_23[r][k] + d_23[r][k];
            end
        end
        @(negedge clk);
        start_23 = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            start_23 = 1'b0;
            seen = (f_valid_23 === 1'b1);
        end
        total++;
        if (!seen || edges != 7 || f_23 !== exp) begin
            bad++;
            $display("[TB] FAIL clear_rerun got edges=%0d f=%h want 7 f=%h", edges, f_23, exp);
        end
        @(negedge clk);
        f_rdy_23 = 1'b1;
        @(posedge clk);
        #1;
        f_rdy_23 = 1'b0;
    endtask

    // Asynchronous reset mid-RUN on the 2x3. Outputs must drop with no clock
    // edge, stay quiet after release, and a new start must complete normally.
    task automatic test_reset_mid_run();
        m23_t exp;
        int edges;
        bit seen;
        bit leaked;
        for (int r = 1; r <= 2; r++) begin
            for (int k = 1; k <= 3; k++) begin
                a_23[r][k] = 8'(r);
                b_23[r][k] = 8'(k * 2);
                c_23[r][k] = 8'd50;
                d_23[r][k] = 8'd250;
                exp[r][k]  = a_23[r][k] + b_23[r][k] + c_23[r][k] + d_23[r][k];
            end
        end
        @(negedge clk);
        start_23 = 1'b1;
        @(posedge clk);
        #1;
        start_23 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset_l = 1'b0;
        #1;
        total++;
        if (f_23 !== '0 || f_valid_23 !== 1'b0 || busy_23 !== 1'b0 || start_rdy_23 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL async_reset got f=%h f_valid=%b busy=%b start_rdy=%b want 0/0/0/1", f_23, f_valid_23, busy_23, start_rdy_23);
        end
        @(negedge clk);
        reset_l = 1'b1;
        leaked = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (f_valid_23 !== 1'b0 || busy_23 !== 1'b0) leaked = 1'b1;
        end
        total++;
        if (leaked) begin
            bad++;
            $display("[TB] FAIL reset_release_quiet got=activity want=idle");
        end
        start_23 = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            start_23 = 1'b0;
            seen = (f_valid_23 === 1'b1);
        end
        total++;
        if (!seen || edges != 7 || f_23 !== exp) begin
            bad++;
            $display("[TB] FAIL reset_rerun got edges=%0d f=%h want 7 f=%h", edges, f_23, exp);
        end
        @(negedge clk);
        f_rdy_23 = 1'b1;
        @(posedge clk);
        #1;
        f_rdy_23 = 1'b0;
        total++;
        if (f_valid_23 !== 1'b0 || start_rdy_23 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_handoff got f_valid=%b start_rdy=%b want 0/1", f_valid_23, start_rdy_23);
        end
    endtask

    // Drive every input to a known value, then run the scenarios in order.
    initial begin
        start_22 = 1'b0; clear_22 = 1'b0; f_rdy_22 = 1'b0;
        a_22 = '0; b_22 = '0; c_22 = '0; d_22 = '0;
        start_11 = 1'b0; clear_11 = 1'b0; f_rdy_11 = 1'b0;
        a_11 = '0; b_11 = '0; c_11 = '0; d_11 = '0;
        start_32 = 1'b0; clear_32 = 1'b0; f_rdy_32 = 1'b0;
        a_32 = '0; b_32 = '0; c_32 = '0; d_32 = '0;
        start_23 = 1'b0; clear_23 = 1'b0; f_rdy_23 = 1'b0;
        a_23 = '0; b_23 = '0; c_23 = '0; d_23 = '0;
        test_reset();
        test_basic_2x2();
        test_1x1();
        test_3x2_capture();
        test_hold_done();
        test_clear();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
